// File: rtl/carga_operandos.sv
// -----------------------------------------------------------------------------
// carga_operandos
// Collects an operand set for a signed 6-bit ALU from a single switch bank and a
// confirm pushbutton. Each debounced press captures one field in turn (A, B,
// opcode). The complete set is then offered downstream until READY accepts it.
//
// Parameters
//   DEB_CYCLES : consecutive stable synchronized cycles needed to accept a
//                button level change (2..255)
// Ports
//   clk    : clock, all state on the rising edge
//   rst    : synchronous active-high reset
//   SW     : operand/opcode switches (quasi-static)
//   BTN    : raw, bouncing confirm pushbutton
//   READY  : downstream ALU accepts the operand set
//   A, B   : captured operands, two's complement, stored bit-exact
//   OP     : captured ALU opcode (SW[2:0] at capture)
//   VALID  : operand set complete and offered downstream
//   ESTADO : current FSM state for the status LEDs
// -----------------------------------------------------------------------------
module carga_operandos #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] SW,
    input  logic       BTN,
    input  logic       READY,
    output logic [5:0] A,
    output logic [5:0] B,
    output logic [2:0] OP,
    output logic       VALID,
    output logic [1:0] ESTADO
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_EXEC = 2'b11
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

    logic              btn_p0;
    logic              btn_p1;
    logic              btn_s;
    logic              deb_stable;
    logic [7:0]        deb_cnt;
    logic              stable_p2;
    logic              press;

    state_t            state;
    state_t            state_next;
    logic              vld_p3;

    logic signed [5:0] a_reg;
    logic signed [5:0] b_reg;
    logic        [2:0] op_reg;

    // ---- stage 0/1: two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= 1'b0;
            btn_p1 <= 1'b0;
        end else begin
            btn_p0 <= BTN;
            btn_p1 <= btn_p0;
        end
    end

    assign btn_s = btn_p1;

    // ---- stage 2: debouncer; any cycle agreeing with the stable level restarts
    // the count, so only an uninterrupted run of DEB_CYCLES differing cycles
    // is accepted as a level change
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_stable <= 1'b0;
            deb_cnt    <= 8'd0;
            stable_p2  <= 1'b0;
        end else begin
            stable_p2 <= deb_stable;
            if (btn_s != deb_stable) begin
                if (deb_cnt == CNT_MAX) begin
                    deb_stable <= btn_s;
                    deb_cnt    <= 8'd0;
                end else begin
                    deb_cnt <= deb_cnt + 8'd1;
                end
            end else begin
                deb_cnt <= 8'd0;
            end
        end
    end

    // One-cycle pulse on the rising edge of the debounced level only
    assign press = deb_stable & ~stable_p2;

    // ---- stage 3: operand FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_A;
            vld_p3 <= 1'b0;
        end else begin
            state  <= state_next;
            // VALID is registered from the next state so it tracks S_EXEC
            // exactly, without a combinational path from READY to the output
            vld_p3 <= (state_next == S_EXEC);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_A:     if (press) state_next = S_B;
            S_B:     if (press) state_next = S_OP;
            S_OP:    if (press) state_next = S_EXEC;
            // Presses here are dropped; the handshake alone leaves S_EXEC
            S_EXEC:  if (READY) state_next = S_A;
            default: state_next = S_A;
        endcase
    end

    // Capture registers sample SW on the same edge as the state transition
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
        end else if (press) begin
            case (state)
                S_A:     a_reg  <= SW;
                S_B:     b_reg  <= SW;
                S_OP:    op_reg <= SW[2:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        A      = a_reg;
        B      = b_reg;
        OP     = op_reg;
        VALID  = vld_p3;
        ESTADO = state;
    end

endmodule

// File: tb/tb_carga_operandos.sv
module tb_carga_operandos;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] SW;
    logic       BTN;
    logic       READY;
    logic [5:0] A;
    logic [5:0] B;
    logic [2:0] OP;
    logic       VALID;
    logic [1:0] ESTADO;

    always #5 clk = ~clk;

    carga_operandos #(.DEB_CYCLES(DEB)) dut (
        .clk    (clk),
        .rst    (rst),
        .SW     (SW),
        .BTN    (BTN),
        .READY  (READY),
        .A      (A),
        .B      (B),
        .OP     (OP),
        .VALID  (VALID),
        .ESTADO (ESTADO)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] op;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur_exp;

    // Abstract model: which field the next press fills, and the field values
    int         phase = 0;
    logic [5:0] m_a = '0;
    logic [5:0] m_b = '0;
    logic [2:0] m_op = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_press(input logic [5:0] sw);
        case (phase)
            0: begin m_a = sw; phase = 1; end
            1: begin m_b = sw; phase = 2; end
            2: begin
                m_op = sw[2:0];
                phase = 3;
                exp_q.push_back('{a: m_a, b: m_b, op: m_op});
            end
            default: ;
        endcase
    endtask

    task automatic model_ready();
        if (phase == 3) phase = 0;
    endtask

    task automatic model_reset();
        phase = 0;
        m_a = '0;
        m_b = '0;
        m_op = '0;
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ESTADO"}, 32'(ESTADO), 32'(phase));
        chk({tag, "_A"}, 32'(A), 32'(m_a));
        chk({tag, "_B"}, 32'(B), 32'(m_b));
        chk({tag, "_OP"}, 32'(OP), 32'(m_op));
        chk({tag, "_VALID"}, 32'(VALID), 32'(phase == 3));
    endtask

    // Monitor: every offered operand set is compared with the scoreboard,
    // and the offer must stay unchanged for as long as VALID is high
    logic vld_d = 1'b0;
    always @(negedge clk) begin
        if (VALID && !vld_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got A=0x%0h B=0x%0h OP=0x%0h, expected no offer", A, B, OP);
            end else begin
                cur_exp = exp_q.pop_front();
                chk("txn_A", 32'(A), 32'(cur_exp.a));
                chk("txn_B", 32'(B), 32'(cur_exp.b));
                chk("txn_OP", 32'(OP), 32'(cur_exp.op));
                chk("txn_ESTADO", 32'(ESTADO), 32'd3);
            end
        end else if (VALID && vld_d) begin
            chk("hold_A", 32'(A), 32'(cur_exp.a));
            chk("hold_B", 32'(B), 32'(cur_exp.b));
            chk("hold_OP", 32'(OP), 32'(cur_exp.op));
        end
        vld_d = VALID;
    end

    // Clean press: long stable high, then long stable low
    task automatic press(input logic [5:0] sw);
        @(negedge clk);
        SW = sw;
        BTN = 1'b1;
        model_press(sw);
        repeat (10) @(negedge clk);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
        check_state("press");
    endtask

    task automatic glitch(input int k);
        @(negedge clk);
        BTN = 1'b1;
        repeat (k) @(negedge clk);
        BTN = 1'b0;
        repeat (8) @(negedge clk);
        check_state("glitch");
    endtask

    task automatic ready_pulse();
        @(negedge clk);
        READY = 1'b1;
        @(negedge clk);
        READY = 1'b0;
        model_ready();
        check_state("ready");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_state("reset");
    endtask

    // Negedges until ESTADO moves, bounded
    task automatic wait_change(output int n);
        logic [1:0] s0;
        s0 = ESTADO;
        n = 0;
        while (ESTADO == s0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1;
        BTN = 1'b0;
        READY = 1'b0;
        SW = 6'h3F;
        repeat (3) @(negedge clk);
        model_reset();
        check_state("init");
        rst = 1'b0;

        // Short pulses never become presses
        SW = 6'h15;
        glitch(3);
        glitch(1);
        glitch(2);

        // Full sequence: -3, +4, opcode 010 (upper switch bits ignored)
        press(6'b111101);
        press(6'b000100);
        press(6'b101010);
        chk("seq_OP", 32'(OP), 32'b010);
        repeat (5) @(negedge clk);
        chk("seq_hold_VALID", 32'(VALID), 32'd1);
        ready_pulse();
        chk("seq_done_A", 32'(A), 32'b111101);

        // Presses while offering are dropped, not queued
        press(6'h0B);
        press(6'h31);
        press(6'h06);
        press(6'h22);
        press(6'h1C);
        ready_pulse();
        repeat (20) @(negedge clk);
        check_state("no_spurious");

        // Reset in S_OP
        press(6'd5);
        press(6'd7);
        do_reset();

        // Press and handshake on the same edge: handshake wins
        press(6'h2D);
        press(6'h12);
        press(6'h03);
        @(negedge clk);
        SW = 6'h11;
        BTN = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        READY = 1'b1;
        @(negedge clk);
        READY = 1'b0;
        model_ready();
        check_state("coincide");
        repeat (10) @(negedge clk);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
        check_state("coincide_after");

        // Bounce, then a long high run: single press DEB+2 edges after the run
        @(negedge clk);
        SW = 6'h2A;
        BTN = 1'b1;
        @(negedge clk);
        BTN = 1'b0;
        @(negedge clk);
        BTN = 1'b1;
        @(negedge clk);
        BTN = 1'b0;
        @(negedge clk);
        BTN = 1'b1;
        model_press(6'h2A);
        wait_change(n);
        chk("bounce_latency", 32'(n), 32'(DEB + 3));
        repeat (3) @(negedge clk);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
        check_state("bounce");

        // Button held through reset release
        @(negedge clk);
        rst = 1'b1;
        BTN = 1'b1;
        SW = 6'h27;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_press(6'h27);
        wait_change(n);
        chk("rst_held_latency", 32'(n), 32'(DEB + 3));
        repeat (5) @(negedge clk);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
        check_state("rst_held");
        press(6'h30);
        press(6'h01);
        ready_pulse();

        // Randomized operand sets with glitches, stray READY and extra presses
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(1, 3)));
                if ($urandom_range(0, 3) == 0) ready_pulse();
                press(6'($urandom));
            end
            repeat ($urandom_range(0, 2)) press(6'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            ready_pulse();
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carga_operandos.md
CARGA_OPERANDOS -- requirements
Module: carga_operandos

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, meaning the number of consecutive stable synchronized cycles needed to accept a button level change (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port SW, input, 6 bits: operand/opcode switches, quasi-static, not synchronized.
REQ-005 The block SHALL have port BTN, input, 1 bit: raw confirm pushbutton, asynchronous and bouncing.
REQ-006 The block SHALL have port READY, input, 1 bit: the downstream ALU (signed 6-bit add/sub/mult stage) accepts the operand set.
REQ-007 The block SHALL have port A, output, 6 bits: registered operand A, two's complement.
REQ-008 The block SHALL have port B, output, 6 bits: registered operand B, two's complement.
REQ-009 The block SHALL have port OP, output, 3 bits: registered ALU opcode.
REQ-010 The block SHALL have port VALID, output, 1 bit: the operand set A/B/OP is complete and offered downstream.
REQ-011 The block SHALL have port ESTADO, output, 2 bits: current FSM state, driven to status LEDs.

Function
REQ-012 BTN SHALL pass through a 2-flop synchronizer; its second-stage output is btn_s.
REQ-013 The debouncer SHALL keep a counter and a stable level; each cycle with btn_s != stable, the counter increments; each cycle with btn_s == stable, it clears to 0.
REQ-014 When btn_s != stable and counter == DEB_CYCLES-1, stable SHALL take btn_s and the counter SHALL clear.
REQ-015 A press SHALL be a one-cycle pulse on the 0->1 transition of stable, detected against a registered copy of stable; 1->0 transitions produce no press.
REQ-016 Latency: if BTN is first sampled high at edge N and stays high, the FSM SHALL act on that press at edge N+DEB_CYCLES+2.
REQ-017 BTN high pulses shorter than DEB_CYCLES synchronized cycles SHALL produce no press.
REQ-018 The FSM SHALL have exactly four states, with encodings on ESTADO: S_A=00, S_B=01, S_OP=10, S_EXEC=11.
REQ-019 On a press in S_A: A <= SW, then go to S_B.
REQ-020 On a press in S_B: B <= SW, then go to S_OP.
REQ-021 On a press in S_OP: OP <= SW[2:0], then go to S_EXEC; SW[5:3] is ignored.
REQ-022 VALID SHALL be 1 exactly while in S_EXEC; it is registered, decoded from state, with no combinational path from READY.
REQ-023 In S_EXEC, a cycle with READY=1 SHALL complete the handshake; the next state is S_A.
REQ-024 A, B and OP SHALL hold unchanged from the capture edge until the next capture of that register, including throughout S_EXEC.
REQ-025 Presses occurring in S_EXEC SHALL be discarded, never queued.
REQ-026 READY SHALL be ignored outside S_EXEC.
REQ-027 If a press and the READY handshake coincide in S_EXEC, the handshake wins and the press is discarded.
REQ-028 A press in any capture state SHALL sample SW on the same edge as the state transition.
REQ-029 Operands SHALL be stored bit-exact; no sign extension, conversion or range check is done here. Sign handling belongs to the ALU.

Reset
REQ-030 On any rising edge with rst=1, the block SHALL set: state=S_A, A=0, B=0, OP=0, VALID=0, synchronizer flops=0, stable=0, counter=0, registered stable copy=0.
REQ-031 Reset SHALL override every other event, including mid-sequence and during S_EXEC with READY=1.
REQ-032 A BTN held high through reset deassertion SHALL yield one press DEB_CYCLES+2 cycles after the first post-reset edge, per REQ-016.

Verification (DEB_CYCLES=4)
REQ-033 Full sequence: SW=6'b111101 (-3) with clean press, SW=6'b000100 (+4) with press, SW=3'b010 with press, READY=0 -> A=111101, B=000100, OP=010, VALID=1, ESTADO=11 and held; READY=1 for one cycle -> VALID=0 and ESTADO=00 on the next edge.
REQ-034 Bounce: BTN toggles 1,0,1,0 at 1-cycle spacing, then holds 1 for 10 cycles -> exactly one press, captured 6 cycles after the start of the final high run.
REQ-035 Glitch: BTN high for 3 cycles only -> no press; ESTADO stays 00; A stays 0.
REQ-036 Ignore in EXEC: two extra clean presses while VALID=1 and READY=0, then READY=1 -> operands unchanged, return to S_A; no spurious capture afterwards.
REQ-037 Reset mid-operation: rst=1 for 1 cycle while in S_OP with A=5 and B=7 -> next edge gives ESTADO=00, A=B=OP=0, VALID=0.
REQ-038 Coincidence: press pulse and READY=1 in the same S_EXEC cycle -> state S_A, A unchanged.
